// File: rtl/ahb_mtx_pkg.sv
// Shared definitions for the AHB matrix blocks: transfer/burst encodings and the
// decode from HBURST to the beat count that the slave arbiters hold a grant for.
package ahb_mtx_pkg;

  localparam int MAX_MASTERS = 16;
  localparam int BURST_LEN_W = 5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  // SINGLE and undefined-length INCR map to 0, meaning "no burst hold".
  function automatic logic [BURST_LEN_W-1:0] hburst_beats(input logic [2:0] hburst);
    logic [BURST_LEN_W-1:0] beats;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
      default:                      beats = 5'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first set bit of mask_i strictly after ptr_i,
// scanning cyclically. Returns the winner one-hot, its index and a found flag.
module ahb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic found;
  int   j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && mask_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: priority levels with round-robin inside a level, grant
// held across locked sequences and defined-length bursts, optional starvation aging.
module ahb_slave_arbiter
  import ahb_mtx_pkg::*;
#(
  parameter int MASTERS    = 4,
  parameter int PRI_W      = $clog2(MASTERS),
  parameter int BURST_HOLD = 1,
  parameter int AGE_LIMIT  = 0,
  parameter int AGE_W      = 8
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [MASTERS-1:0]           req,
  input  logic [MASTERS-1:0]           lock,
  input  logic [MASTERS*5-1:0]         burst_len,
  input  logic [MASTERS*PRI_W-1:0]     prio,
  input  logic                         addr_ack,
  output logic [MASTERS-1:0]           grant,
  output logic [$clog2(MASTERS)-1:0]   grant_idx,
  output logic                         grant_valid,
  output logic                         hold,
  output logic [1:0]                   dbg_state_o
);

  localparam int IW = $clog2(MASTERS);

  // ARB: grant freshly registered, first ack not yet seen. OWN: held after an ack.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARB  = 2'd1;
  localparam logic [1:0] S_OWN  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [MASTERS-1:0]     grant_q, grant_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   gv_q, gv_d;
  logic                   hold_q, hold_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [BURST_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [AGE_W-1:0]       age_q [MASTERS];
  logic [AGE_W-1:0]       age_d [MASTERS];

  logic [PRI_W-1:0]       eff_lvl [MASTERS];
  logic [PRI_W-1:0]       min_lvl;
  logic [MASTERS-1:0]     cand;
  logic [MASTERS-1:0]     pick_oh;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;

  logic                   owner_req, owner_lock, hold_next;
  logic                   ack_ok, abort, decide;
  logic [BURST_LEN_W-1:0] owner_blen, cnt_cur;

  // A master whose age reached the limit competes at level 0.
  always_comb begin
    min_lvl = '1;
    cand    = '0;
    for (int i = 0; i < MASTERS; i++) begin
      eff_lvl[i] = prio[i*PRI_W +: PRI_W];
      if (AGE_LIMIT != 0 && age_q[i] == AGE_W'(AGE_LIMIT)) eff_lvl[i] = '0;
      if (req[i] && eff_lvl[i] < min_lvl) min_lvl = eff_lvl[i];
    end
    for (int i = 0; i < MASTERS; i++) begin
      cand[i] = req[i] && (eff_lvl[i] == min_lvl);
    end
  end

  ahb_rr_pick #(.N(MASTERS), .IW(IW)) u_pick (
    .mask_i  (cand),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_oh),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    owner_req  = |(req & grant_q);
    owner_lock = |(lock & grant_q);
    owner_blen = burst_len[int'(idx_q)*BURST_LEN_W +: BURST_LEN_W];
    // beat_cnt holds beats still owed after the last ack; first ack uses burst_len.
    cnt_cur    = (state_q == S_ARB) ? owner_blen : beat_cnt_q;
    hold_next  = owner_lock || ((BURST_HOLD != 0) && (cnt_cur > 5'd1));
    ack_ok     = gv_q && addr_ack && owner_req;
    abort      = gv_q && !owner_req;
    decide     = !gv_q || (ack_ok && !hold_next);
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    gv_d       = gv_q;
    hold_d     = hold_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (abort) begin
      state_d    = S_IDLE;
      grant_d    = '0;
      idx_d      = '0;
      gv_d       = 1'b0;
      hold_d     = 1'b0;
      beat_cnt_d = '0;
    end else if (decide) begin
      beat_cnt_d = '0;
      hold_d     = 1'b0;
      if (pick_valid) begin
        state_d  = S_ARB;
        grant_d  = pick_oh;
        idx_d    = pick_idx;
        gv_d     = 1'b1;
        rr_ptr_d = pick_idx;
      end else begin
        state_d  = S_IDLE;
        grant_d  = '0;
        idx_d    = '0;
        gv_d     = 1'b0;
      end
    end else if (ack_ok) begin
      state_d    = S_OWN;
      hold_d     = 1'b1;
      beat_cnt_d = (cnt_cur != '0) ? cnt_cur - 5'd1 : '0;
    end
  end

  always_comb begin
    for (int i = 0; i < MASTERS; i++) begin
      age_d[i] = age_q[i];
      if (AGE_LIMIT == 0 || !req[i] || grant_q[i] || grant_d[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] != AGE_W'(AGE_LIMIT)) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      idx_q      <= '0;
      gv_q       <= 1'b0;
      hold_q     <= 1'b0;
      rr_ptr_q   <= IW'(MASTERS-1);
      beat_cnt_q <= '0;
      for (int i = 0; i < MASTERS; i++) age_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      gv_q       <= gv_d;
      hold_q     <= hold_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      for (int i = 0; i < MASTERS; i++) age_q[i] <= age_d[i];
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = gv_q;
  assign hold        = hold_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed bench for ahb_slave_arbiter: default build, a no-burst-hold build and an
// aging build share the same stimulus; each check names the instance it looks at.
module tb_ahb_slave_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  lock = '0;
  logic [19:0] burst_len = '0;
  logic [7:0]  prio = '0;
  logic        addr_ack = 1'b0;

  logic [3:0] a_grant, n_grant, g_grant;
  logic [1:0] a_idx, n_idx, g_idx;
  logic       a_gv, n_gv, g_gv;
  logic       a_hold, n_hold, g_hold;
  logic [1:0] a_st, n_st, g_st;

  int n_checks = 0;
  int n_errors = 0;
  int found_at;
  logic [31:0] exp_q[$];

  always #5 HCLK = ~HCLK;

  ahb_slave_arbiter #(.MASTERS(4)) dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .lock(lock), .burst_len(burst_len),
    .prio(prio), .addr_ack(addr_ack), .grant(a_grant), .grant_idx(a_idx),
    .grant_valid(a_gv), .hold(a_hold), .dbg_state_o(a_st)
  );

  ahb_slave_arbiter #(.MASTERS(4), .BURST_HOLD(0)) dut_n (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .lock(lock), .burst_len(burst_len),
    .prio(prio), .addr_ack(addr_ack), .grant(n_grant), .grant_idx(n_idx),
    .grant_valid(n_gv), .hold(n_hold), .dbg_state_o(n_st)
  );

  ahb_slave_arbiter #(.MASTERS(4), .AGE_LIMIT(5)) dut_g (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .lock(lock), .burst_len(burst_len),
    .prio(prio), .addr_ack(addr_ack), .grant(g_grant), .grant_idx(g_idx),
    .grant_valid(g_gv), .hold(g_hold), .dbg_state_o(g_st)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESETn   = 1'b0;
    req       = '0;
    lock      = '0;
    burst_len = '0;
    prio      = '0;
    addr_ack  = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    check("rst_a_gv", a_gv, 0);
    check("rst_a_grant", a_grant, 0);
    check("rst_a_idx", a_idx, 0);
    check("rst_a_hold", a_hold, 0);
    check("rst_a_state", a_st, 0);
    check("rst_n_gv", n_gv, 0);
    check("rst_g_gv", g_gv, 0);
  endtask

  initial begin
    // Idle: nothing requested, nothing granted.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_gv", a_gv, 0);
      check("idle_grant", a_grant, 0);
    end

    // Round-robin among equal levels, one owner per ack, starting after rr_ptr=3.
    do_reset();
    prio = 8'h55; req = 4'hF; addr_ack = 1'b1;
    exp_q = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    while (exp_q.size() > 0) begin
      tick();
      check("rr_gv", a_gv, 1);
      check("rr_idx", a_idx, exp_q.pop_front());
    end

    // Fixed priority: master 0 at level 0 keeps winning; after it drops, master 1.
    do_reset();
    prio = 8'b11_10_01_00; req = 4'hF; addr_ack = 1'b1;
    repeat (3) begin
      tick();
      check("pri_idx", a_idx, 0);
      check("pri_grant", a_grant, 4'b0001);
    end
    addr_ack = 1'b0; req = 4'b1110;
    tick();
    check("pri_abort_gv", a_gv, 0);
    tick();
    check("pri_next_gv", a_gv, 1);
    check("pri_next_idx", a_idx, 1);

    // Burst of 4 on master 2 with master 1 waiting.
    do_reset();
    prio = 8'h55; burst_len = {5'd0, 5'd4, 5'd0, 5'd0};
    req = 4'b0100;
    tick();
    check("burst_first_a", a_idx, 2);
    check("burst_first_n", n_idx, 2);
    req = 4'b0110; addr_ack = 1'b1;
    exp_q = {32'd2, 32'd2, 32'd2, 32'd1};
    for (int b = 0; b < 4; b++) begin
      tick();
      check("burst_hold_idx", a_idx, exp_q.pop_front());
      check("burst_hold_flag", a_hold, (b < 3) ? 1 : 0);
      check("burst_nohold_idx", n_idx, (b % 2 == 0) ? 1 : 2);
    end

    // Lock held for three acks, then released; then an abort by the new owner.
    do_reset();
    prio = 8'h55; req = 4'b0010; lock = 4'b0010;
    tick();
    check("lock_first_idx", a_idx, 1);
    req = 4'b0011; addr_ack = 1'b1;
    repeat (3) begin
      tick();
      check("lock_idx", a_idx, 1);
      check("lock_hold", a_hold, 1);
    end
    lock = 4'b0000;
    tick();
    check("unlock_idx", a_idx, 0);
    check("unlock_hold", a_hold, 0);
    addr_ack = 1'b0; req = 4'b0010;
    tick();
    check("abort_gv", a_gv, 0);
    check("abort_grant", a_grant, 0);
    tick();
    check("abort_regrant_gv", a_gv, 1);
    check("abort_regrant_idx", a_idx, 1);

    // Lock keeps the grant after a 2-beat burst count has run out.
    do_reset();
    prio = 8'h55; burst_len = {5'd0, 5'd0, 5'd2, 5'd0}; req = 4'b0010; lock = 4'b0010;
    tick();
    req = 4'b0011; addr_ack = 1'b1;
    repeat (4) begin
      tick();
      check("lockburst_idx", a_idx, 1);
      check("lockburst_hold", a_hold, 1);
    end
    lock = 4'b0000;
    tick();
    check("lockburst_release", a_idx, 0);

    // Aging: master 3 at level 3 against master 0 at level 0.
    do_reset();
    prio = 8'b11_01_01_00; req = 4'b1001; addr_ack = 1'b1;
    found_at = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (found_at == 0 && g_gv && g_idx == 2'd3) found_at = c;
      check("noage_idx", a_idx, 0);
    end
    check("age_promote_cycle", found_at, 6);

    // Asynchronous reset in the middle of a held burst.
    do_reset();
    prio = 8'h55; burst_len = {5'd0, 5'd4, 5'd0, 5'd0}; req = 4'b0100;
    tick();
    addr_ack = 1'b1;
    tick();
    check("midrst_pre_hold", a_hold, 1);
    check("midrst_pre_idx", a_idx, 2);
    HRESETn = 1'b0;
    #1;
    check("midrst_gv", a_gv, 0);
    check("midrst_grant", a_grant, 0);
    check("midrst_idx", a_idx, 0);
    check("midrst_hold", a_hold, 0);
    check("midrst_state", a_st, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
